// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the IF (read-only) and DM
// (read/write) ports. Optional IF starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int LAT        = 1,
   parameter int MAX_STARVE = 4
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   input  logic            if_kill,
   output logic            if_done,
   output logic [DW-1:0]   if_rdata,
   input  logic            dm_req,
   input  logic            dm_we,
   input  logic [AW-1:0]   dm_addr,
   input  logic [DW-1:0]   dm_wdata,
   input  logic [DW/8-1:0] dm_be,
   output logic            dm_done,
   output logic [DW-1:0]   dm_rdata,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic [DW-1:0]   mem_rdata,
   output logic            busy
);

   localparam int         BW      = DW / 8;
   localparam logic [3:0] LAT_CNT = 4'(LAT);
   localparam logic       OWN_IF  = 1'b0;
   localparam logic       OWN_DM  = 1'b1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t          state_reg, state_next;
   logic            owner_reg, owner_next;
   logic [AW-1:0]   addr_reg, addr_next;
   logic            we_reg, we_next;
   logic [DW-1:0]   wdata_reg, wdata_next;
   logic [BW-1:0]   be_reg, be_next;
   logic [3:0]      cnt_reg, cnt_next;
   logic            killed_reg, killed_next;
   logic [DW-1:0]   if_rdata_reg, if_rdata_next;
   logic [DW-1:0]   dm_rdata_reg, dm_rdata_next;
   logic            grant_dm, grant_if;
   logic            issue;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

   logic [3:0] starve_reg, starve_next;
   logic       force_if;

   // Once DM has won STARVE_LIM times over a live IF request, IF takes the next slot.
   assign force_if = (starve_reg == STARVE_LIM) && if_req && !if_kill;
   assign grant_dm = dm_req && !force_if;
   assign grant_if = if_req && !if_kill && (!dm_req || force_if);

   always_comb begin
      starve_next = starve_reg;
      if (state_reg == IDLE) begin
         if (grant_if)
            starve_next = '0;
         else if (grant_dm && if_req && !if_kill && (starve_reg != STARVE_LIM))
            starve_next = starve_reg + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         starve_reg <= '0;
      else
         starve_reg <= starve_next;
   end
`else
   assign grant_dm = dm_req;
   assign grant_if = if_req && !if_kill && !dm_req;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         owner_reg    <= OWN_IF;
         addr_reg     <= '0;
         we_reg       <= 1'b0;
         wdata_reg    <= '0;
         be_reg       <= '0;
         cnt_reg      <= '0;
         killed_reg   <= 1'b0;
         if_rdata_reg <= '0;
         dm_rdata_reg <= '0;
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         addr_reg     <= addr_next;
         we_reg       <= we_next;
         wdata_reg    <= wdata_next;
         be_reg       <= be_next;
         cnt_reg      <= cnt_next;
         killed_reg   <= killed_next;
         if_rdata_reg <= if_rdata_next;
         dm_rdata_reg <= dm_rdata_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      owner_next    = owner_reg;
      addr_next     = addr_reg;
      we_next       = we_reg;
      wdata_next    = wdata_reg;
      be_next       = be_reg;
      cnt_next      = cnt_reg;
      killed_next   = killed_reg;
      if_rdata_next = if_rdata_reg;
      dm_rdata_next = dm_rdata_reg;
      if_done       = 1'b0;
      dm_done       = 1'b0;

      case (state_reg)
         IDLE: begin
            killed_next = 1'b0;
            if (grant_dm) begin
               owner_next = OWN_DM;
               addr_next  = dm_addr;
               we_next    = dm_we;
               wdata_next = dm_wdata;
               be_next    = dm_be;
               state_next = ISSUE;
            end else if (grant_if) begin
               owner_next = OWN_IF;
               addr_next  = if_addr;
               we_next    = 1'b0;
               be_next    = '1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            cnt_next   = LAT_CNT;
            state_next = WAIT;
            if (owner_reg == OWN_IF && if_kill)
               killed_next = 1'b1;
         end
         WAIT: begin
            cnt_next = cnt_reg - 4'd1;
            if (owner_reg == OWN_IF && if_kill)
               killed_next = 1'b1;
            if (cnt_reg == 4'd1) begin
               state_next = DONE;
               // A killed fetch must not disturb the last good instruction word.
               if (!we_reg) begin
                  if (owner_reg == OWN_DM)
                     dm_rdata_next = mem_rdata;
                  else if (!killed_reg && !if_kill)
                     if_rdata_next = mem_rdata;
               end
            end
         end
         DONE: begin
            if (owner_reg == OWN_DM)
               dm_done = 1'b1;
            else
               if_done = !killed_reg && !if_kill;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign issue     = (state_reg == ISSUE);
   assign mem_en    = issue;
   assign mem_we    = issue && we_reg;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign busy      = (state_reg != IDLE);
   assign if_rdata  = if_rdata_reg;
   assign dm_rdata  = dm_rdata_reg;

   generate
      for (genvar gi = 0; gi < BW; gi++) begin : g_be
         assign mem_be[gi] = issue && be_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (LAT=1 and LAT=2) share the
// request inputs, each with its own behavioural memory.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0, if_kill = 1'b0;
   logic [31:0] if_addr = '0;
   logic        dm_req = 1'b0, dm_we = 1'b0;
   logic [31:0] dm_addr = '0, dm_wdata = '0;
   logic [3:0]  dm_be = '0;

   logic        if_done1, dm_done1, mem_en1, mem_we1, busy1;
   logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic [3:0]  mem_be1;
   logic        if_done2, dm_done2, mem_en2, mem_we2, busy2;
   logic [31:0] if_rdata2, dm_rdata2, mem_addr2, mem_wdata2, mem_rdata2, stage2;
   logic [3:0]  mem_be2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32), .LAT(1), .MAX_STARVE(4)) u_dut1 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_done(if_done1), .if_rdata(if_rdata1),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
      .dm_done(dm_done1), .dm_rdata(dm_rdata1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_be(mem_be1), .mem_rdata(mem_rdata1), .busy(busy1)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .LAT(2), .MAX_STARVE(4)) u_dut2 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_done(if_done2), .if_rdata(if_rdata2),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
      .dm_done(dm_done2), .dm_rdata(dm_rdata2),
      .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .mem_be(mem_be2), .mem_rdata(mem_rdata2), .busy(busy2)
   );

   // Word memories; read data is only meaningful exactly LAT cycles after mem_en.
   logic [31:0] mem1 [256];
   logic [31:0] mem2 [256];

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem1[i] = {16'hC0DE, i[7:0], i[7:0]};
         mem2[i] = {16'hC0DE, i[7:0], i[7:0]};
      end
      mem1[16] = 32'hDEADBEEF;
      mem2[16] = 32'hDEADBEEF;
   end

   always @(posedge clk) begin
      if (mem_en1 && mem_we1)
         for (int b = 0; b < 4; b++)
            if (mem_be1[b]) mem1[mem_addr1[9:2]][b*8 +: 8] <= mem_wdata1[b*8 +: 8];
      mem_rdata1 <= (mem_en1 && !mem_we1) ? mem1[mem_addr1[9:2]] : 32'hBAD0_0001;
   end

   always @(posedge clk) begin
      if (mem_en2 && mem_we2)
         for (int b = 0; b < 4; b++)
            if (mem_be2[b]) mem2[mem_addr2[9:2]][b*8 +: 8] <= mem_wdata2[b*8 +: 8];
      stage2     <= (mem_en2 && !mem_we2) ? mem2[mem_addr2[9:2]] : 32'hBAD0_0002;
      mem_rdata2 <= stage2;
   end

   // Per-cycle log of both instances: index 0 = LAT=1, index 1 = LAT=2.
   bit          lg_en   [2][64];
   bit          lg_we   [2][64];
   bit          lg_ifd  [2][64];
   bit          lg_dmd  [2][64];
   bit          lg_busy [2][64];
   logic [3:0]  lg_be   [2][64];
   logic [31:0] lg_addr [2][64];
   logic [31:0] lg_ifr  [2][64];
   logic [31:0] lg_dmr  [2][64];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      if_req  = 1'b0;
      dm_req  = 1'b0;
      if_kill = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Runs n cycles starting at posedge+1; the requester drops its req after its
   // done (of instance sel), a kill, or a reset. hold_dm keeps dm_req asserted.
   task automatic run_window(input int sel, input int n, input int kill_cyc,
                             input int rst_cyc, input bit hold_dm);
      bit drop_if, drop_dm;
      for (int c = 0; c < n; c++) begin
         if_kill = (c == kill_cyc);
         reset   = (c == rst_cyc);
         @(negedge clk);
         lg_en[0][c] = mem_en1;  lg_we[0][c] = mem_we1;  lg_be[0][c] = mem_be1;
         lg_addr[0][c] = mem_addr1; lg_ifd[0][c] = if_done1; lg_dmd[0][c] = dm_done1;
         lg_busy[0][c] = busy1;  lg_ifr[0][c] = if_rdata1; lg_dmr[0][c] = dm_rdata1;
         lg_en[1][c] = mem_en2;  lg_we[1][c] = mem_we2;  lg_be[1][c] = mem_be2;
         lg_addr[1][c] = mem_addr2; lg_ifd[1][c] = if_done2; lg_dmd[1][c] = dm_done2;
         lg_busy[1][c] = busy2;  lg_ifr[1][c] = if_rdata2; lg_dmr[1][c] = dm_rdata2;
         drop_if = (c == kill_cyc) || (c == rst_cyc) || ((sel == 0) ? if_done1 : if_done2);
         drop_dm = !hold_dm && ((c == rst_cyc) || ((sel == 0) ? dm_done1 : dm_done2));
         @(posedge clk);
         #1;
         if (drop_if) if_req = 1'b0;
         if (drop_dm) dm_req = 1'b0;
      end
      if_kill = 1'b0;
      reset   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_addr;

      // Reset state
      do_reset();
      reset = 1'b1;
      @(negedge clk);
      check_eq("rst_busy", busy1, 0);
      check_eq("rst_en", mem_en1, 0);
      check_eq("rst_ifd", if_done1, 0);
      check_eq("rst_dmd", dm_done1, 0);
      check_eq("rst_ifr", if_rdata1, 0);
      check_eq("rst_dmr", dm_rdata1, 0);
      check_eq("rst_addr", mem_addr1, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      $display("txn reset: outputs sampled");

      // IF read alone, LAT=1 (and LAT=2 alongside)
      if_req = 1'b1; if_addr = 32'h40;
      run_window(0, 6, -1, -1, 1'b0);
      for (int c = 0; c < 6; c++) begin
         check_eq($sformatf("t1_en_c%0d", c), lg_en[0][c], (c == 1));
         check_eq($sformatf("t1_ifd_c%0d", c), lg_ifd[0][c], (c == 3));
      end
      check_eq("t1_addr", lg_addr[0][1], 32'h40);
      check_eq("t1_we", lg_we[0][1], 0);
      check_eq("t1_ifr", lg_ifr[0][3], 32'hDEADBEEF);
      check_eq("t1_busy3", lg_busy[0][3], 1);
      check_eq("t1_busy4", lg_busy[0][4], 0);
      check_eq("t1_l2_ifd3", lg_ifd[1][3], 0);
      check_eq("t1_l2_ifd4", lg_ifd[1][4], 1);
      check_eq("t1_l2_ifr", lg_ifr[1][4], 32'hDEADBEEF);
      $display("txn if_read: addr 40 if_rdata %0h", lg_ifr[0][3]);

      // DM read, then DM write, then read-back
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44; dm_be = 4'h0;
      run_window(0, 5, -1, -1, 1'b0);
      check_eq("t2_rd_done", lg_dmd[0][3], 1);
      check_eq("t2_rd_data", lg_dmr[0][3], 32'hC0DE1111);
      $display("txn dm_read: addr 44 dm_rdata %0h", lg_dmr[0][3]);

      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h12345678; dm_be = 4'b0011;
      run_window(0, 5, -1, -1, 1'b0);
      check_eq("t2_wr_en", lg_en[0][1], 1);
      check_eq("t2_wr_we", lg_we[0][1], 1);
      check_eq("t2_wr_be", lg_be[0][1], 4'b0011);
      check_eq("t2_wr_addr", lg_addr[0][1], 32'h100);
      check_eq("t2_wr_we_wait", lg_we[0][2], 0);
      check_eq("t2_wr_be_wait", lg_be[0][2], 0);
      check_eq("t2_wr_done", lg_dmd[0][3], 1);
      check_eq("t2_wr_done4", lg_dmd[0][4], 0);
      check_eq("t2_wr_dmr", lg_dmr[0][3], 32'hC0DE1111);
      $display("txn dm_write: addr 100 wdata 12345678 be 3");

      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_be = 4'h0;
      run_window(0, 5, -1, -1, 1'b0);
      check_eq("t2_rb_data", lg_dmr[0][3], 32'hC0DE5678);
      $display("txn dm_readback: addr 100 dm_rdata %0h", lg_dmr[0][3]);

      // Contention, LAT=2
      do_reset();
      if_req = 1'b1; if_addr = 32'h40;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44; dm_be = 4'h0;
      run_window(1, 12, -1, -1, 1'b0);
      check_eq("t3_dm_addr", lg_addr[1][1], 32'h44);
      check_eq("t3_dmd3", lg_dmd[1][3], 0);
      check_eq("t3_dmd4", lg_dmd[1][4], 1);
      check_eq("t3_dmr", lg_dmr[1][4], 32'hC0DE1111);
      check_eq("t3_busy5", lg_busy[1][5], 0);
      check_eq("t3_if_en6", lg_en[1][6], 1);
      check_eq("t3_if_addr", lg_addr[1][6], 32'h40);
      check_eq("t3_ifd8", lg_ifd[1][8], 0);
      check_eq("t3_ifd9", lg_ifd[1][9], 1);
      check_eq("t3_ifr", lg_ifr[1][9], 32'hDEADBEEF);
      $display("txn contention: dm_done c4 if_done c9 expected");

      // Kill during WAIT
      do_reset();
      if_req = 1'b1; if_addr = 32'h40;
      run_window(0, 6, -1, -1, 1'b0);
      if_req = 1'b1; if_addr = 32'h44;
      run_window(0, 6, 2, -1, 1'b0);
      for (int c = 0; c < 6; c++)
         check_eq($sformatf("t4_ifd_c%0d", c), lg_ifd[0][c], 0);
      check_eq("t4_en1", lg_en[0][1], 1);
      check_eq("t4_busy3", lg_busy[0][3], 1);
      check_eq("t4_busy4", lg_busy[0][4], 0);
      check_eq("t4_ifr", lg_ifr[0][5], 32'hDEADBEEF);
      check_eq("t4_l2_ifd4", lg_ifd[1][4], 0);
      check_eq("t4_l2_ifr", lg_ifr[1][5], 32'hDEADBEEF);
      $display("txn if_kill: addr 44 killed in WAIT");

      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
      run_window(0, 5, 1, -1, 1'b0);
      check_eq("t4_dm_done", lg_dmd[0][3], 1);
      check_eq("t4_dm_data", lg_dmr[0][3], 32'hC0DE1111);
      $display("txn dm_after_kill: dm_rdata %0h", lg_dmr[0][3]);

      // Reset in WAIT of a DM read
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
      run_window(0, 7, -1, 2, 1'b0);
      check_eq("t5_busy2", lg_busy[0][2], 1);
      check_eq("t5_busy3", lg_busy[0][3], 0);
      check_eq("t5_addr3", lg_addr[0][3], 0);
      check_eq("t5_dmr3", lg_dmr[0][3], 0);
      check_eq("t5_ifr3", lg_ifr[0][3], 0);
      for (int c = 2; c < 7; c++) begin
         check_eq($sformatf("t5_dmd_c%0d", c), lg_dmd[0][c], 0);
         if (c >= 3) check_eq($sformatf("t5_en_c%0d", c), lg_en[0][c], 0);
      end
      $display("txn reset_mid_wait: abandoned");

      // Continuous DM traffic against a pending IF request
      do_reset();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
      if_req = 1'b1; if_addr = 32'h40;
      run_window(0, 24, -1, -1, 1'b1);
      for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
         exp_addr = (k == 4) ? 32'h40 : 32'h80;
`else
         exp_addr = 32'h80;
`endif
         check_eq($sformatf("t6_en_k%0d", k), lg_en[0][1 + 4*k], 1);
         check_eq($sformatf("t6_addr_k%0d", k), lg_addr[0][1 + 4*k], exp_addr);
      end
`ifdef MEM_ARB_STARVE_GUARD_EN
      check_eq("t6_ifd19", lg_ifd[0][19], 1);
`else
      check_eq("t6_ifd19", lg_ifd[0][19], 0);
`endif
      dm_req = 1'b0;
      if_req = 1'b0;
      $display("txn starvation: six grants logged");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates a single shared single-port memory between the fetch stage's instruction port (IF, read-only) and the MEM stage's data port (DM, read/write).
- Sequences each access through fixed-latency memory timing and returns read data and a done pulse to the owning requester.
- Supports fetch-kill on branch redirect and data-port priority, with an optional starvation guard.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; must be a multiple of 8.
- LAT, 1, memory read latency in cycles after mem_en; legal range 1..15.
- MAX_STARVE, 4, consecutive DM wins over a pending IF request before IF is forced (used only with the optional feature).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- if_req  input  1  IF request; held high until if_done or if_kill
- if_addr  input  AW  IF address; stable while if_req is high
- if_kill  input  1  cancel IF transaction (branch redirect)
- if_done  output  1  one-cycle pulse; if_rdata valid
- if_rdata  output  DW  IF read data
- dm_req  input  1  DM request; held high until dm_done
- dm_we  input  1  1 = write, 0 = read
- dm_addr  input  AW  DM address
- dm_wdata  input  DW  DM write data
- dm_be  input  DW/8  DM byte enables (writes only)
- dm_done  output  1  one-cycle pulse; dm_rdata valid for reads
- dm_rdata  output  DW  DM read data
- mem_en  output  1  memory access strobe, one cycle per transaction
- mem_we  output  1  memory write enable, qualified by mem_en
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_be  output  DW/8  memory byte enables
- mem_rdata  input  DW  memory read data, valid LAT cycles after mem_en
- busy  output  1  high in any state other than IDLE

Behaviour:
- States are IDLE, ISSUE, WAIT, DONE.
- Grant (IDLE, cycle T):
  - If dm_req is high, DM wins.
  - Else if if_req is high and if_kill is low, IF wins.
  - Else stay in IDLE.
  - On a grant, latch the owner, addr, we, wdata and be, then go to ISSUE. Owner we is forced to 0 for IF.
- ISSUE (T+1):
  - mem_en=1; mem_we, mem_addr, mem_wdata and mem_be come from the latched values.
  - Load the latency counter with LAT and go to WAIT.
- WAIT (T+2 .. T+1+LAT):
  - The counter decrements each cycle.
  - In the cycle where the counter equals 1, capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
- DONE (T+2+LAT):
  - Pulse the owner's done for one cycle, then go to IDLE.
  - During DONE, requests are not sampled, so the owner's still-high req cannot re-grant.
- Throughput is one transaction per LAT+3 cycles. Load-to-done latency is LAT+2 cycles after the grant cycle.
- Writes follow the same sequence. dm_done pulses, and dm_rdata holds its previous value.
- Kill:
  - If if_kill is high in any cycle while IF is the owner (ISSUE, WAIT or DONE), set the killed flag.
  - The memory transaction still completes its full timing.
  - if_done is suppressed in DONE if killed is set or if_kill is high that cycle. if_rdata is not updated.
  - killed clears on return to IDLE.
- if_kill while DM is the owner has no effect.
- Simultaneous dm_req and if_req in IDLE: DM wins (see Optional Feature).
- mem_en, mem_we and mem_be are 0 outside ISSUE. mem_addr and mem_wdata hold their latched values.
- Reset: all outputs are 0 (done pulses, rdata registers, mem_* and busy), state is IDLE, and the counter, killed flag and starvation counter are 0.
- Reset asserted mid-transaction abandons it: no done pulse follows, and any in-flight mem_rdata is ignored.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit starve counter increments on each DM grant made while if_req is high and if_kill is low.
  - When the counter equals MAX_STARVE, IF wins the next IDLE arbitration even if dm_req is high.
  - The counter clears on every IF grant and on reset, and saturates at MAX_STARVE.
- Undefined: strict DM priority, and no counter logic is present.

Test Plan:
- IF read alone: LAT=1, if_req at cycle 0, addr 0x40, mem returns 0xDEADBEEF → mem_en high in cycle 1 only; if_done high in cycle 3 only with if_rdata=0xDEADBEEF; busy low in cycle 4.
- DM write: dm_we=1, addr 0x100, wdata 0x12345678, be 4'b0011 → mem_en=mem_we=1 and mem_be=0011 in the ISSUE cycle; dm_done pulses once; dm_rdata unchanged.
- Contention: if_req and dm_req both high at cycle 0, LAT=2 → DM serviced first with dm_done at cycle 4; IF granted at cycle 5; if_done at cycle 9.
- Kill: IF granted, if_kill pulsed in WAIT → no if_done; if_rdata retains its old value; busy drops on schedule; a subsequent DM request is serviced normally.
- Reset mid-WAIT: reset asserted during WAIT of a DM read → the next cycle shows IDLE, all outputs 0, and no dm_done.
- Starvation (macro on, MAX_STARVE=4): dm_req continuously high with if_req high → 4 DM transactions, then an IF grant, then DM resumes.
